// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit with byte-serial handling of misaligned stores
// and two-read assembly of word-crossing loads. Rev 1.0
`default_nettype none

module load_store_unit #(
  parameter int DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [2:0]                  req_funct3,
  input  logic [31:0]                 req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_err,
  output logic [$clog2(DEPTH)-1:0]    mem_rd_addr,
  input  logic [31:0]                 mem_rd_data,
  output logic [$clog2(DEPTH)-1:0]    mem_wr_addr,
  output logic [31:0]                 mem_wr_data,
  output logic                        mem_we,
  output logic [2:0]                  mem_wr_strb
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WRB  = 3'd2,
    RD0  = 3'd3,
    RD1  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t              r_state;
  logic [2:0]          r_f3;
  logic [ADDR_W+1:0]   r_addr_lo;
  logic [31:0]         r_wdata;
  logic [2:0]          r_n;
  logic [1:0]          r_cnt;
  logic [31:0]         r_lo;
  logic                r_mem_we;
  logic [2:0]          r_mem_wr_strb;
  logic [ADDR_W-1:0]   r_mem_wr_addr;
  logic [31:0]         r_mem_wr_data;
  logic [ADDR_W-1:0]   r_mem_rd_addr;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;

  // Request decode, used only on the accept edge.
  logic [2:0]          w_n;
  logic [1:0]          w_off;
  logic                w_legal;
  logic                w_cross;
  logic                w_oob;
  logic                w_err;
  logic                w_st_align;
  logic [2:0]          w_al_strb;
  logic [31:0]         w_al_data;

  assign w_n     = req_funct3[1] ? 3'd4 : (req_funct3[0] ? 3'd2 : 3'd1);
  assign w_off   = req_addr[1:0];
  assign w_legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign w_cross = (({1'b0, w_off} + w_n) > 3'd4);
  // The last byte leaves memory only when the access spills past the top word.
  assign w_oob   = (req_addr[31:ADDR_W+2] != '0) || ((&req_addr[ADDR_W+1:2]) && w_cross);
  assign w_err   = !w_legal || w_oob;
  assign w_st_align = (w_n == 3'd1) || ((w_n == 3'd2) && !w_off[0]) ||
                      ((w_n == 3'd4) && (w_off == 2'b00));

  always_comb begin
    w_al_strb = {1'b1, w_off};
    w_al_data = {24'b0, req_wdata[7:0]};
    if (w_n == 3'd4) begin
      w_al_strb = 3'b000;
      w_al_data = req_wdata;
    end else if (w_n == 3'd2) begin
      w_al_strb = w_off[1] ? 3'b011 : 3'b001;
      w_al_data = {16'b0, req_wdata[15:0]};
    end
  end

  // Byte-serial writer: byte 0 comes straight from the request, later bytes from registers.
  logic                w_is_idle;
  logic [1:0]          w_idx;
  logic [ADDR_W+1:0]   w_src_lo;
  logic [31:0]         w_src_wd;
  logic [ADDR_W+1:0]   w_ba;
  logic [7:0]          w_byte;

  assign w_is_idle = (r_state == IDLE);
  assign w_idx     = w_is_idle ? 2'd0 : (r_cnt + 2'd1);
  assign w_src_lo  = w_is_idle ? req_addr[ADDR_W+1:0] : r_addr_lo;
  assign w_src_wd  = w_is_idle ? req_wdata : r_wdata;
  assign w_ba      = w_src_lo + (ADDR_W+2)'(w_idx);
  assign w_byte    = 8'(w_src_wd >> {w_idx, 3'b000});

  // Load assembly: a crossing load sees {word w+1, word w} as one little-endian pair.
  logic [1:0]          w_r_off;
  logic                w_r_cross;
  logic [63:0]         w_pair;
  logic [31:0]         w_raw;
  logic [31:0]         w_ext;

  assign w_r_off   = r_addr_lo[1:0];
  assign w_r_cross = (({1'b0, w_r_off} + r_n) > 3'd4);
  assign w_pair    = (r_state == RD1) ? {mem_rd_data, r_lo} : {32'b0, mem_rd_data};
  assign w_raw     = 32'(w_pair >> {w_r_off, 3'b000});

  always_comb begin
    w_ext = w_raw;
    case (r_f3)
      3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_ext = {24'b0, w_raw[7:0]};
      3'b101:  w_ext = {16'b0, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_f3          <= '0;
      r_addr_lo     <= '0;
      r_wdata       <= '0;
      r_n           <= '0;
      r_cnt         <= '0;
      r_lo          <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wr_strb <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_mem_rd_addr <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      r_mem_we      <= 1'b0;
      r_mem_wr_strb <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_mem_rd_addr <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= '0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_f3      <= req_funct3;
            r_addr_lo <= req_addr[ADDR_W+1:0];
            r_wdata   <= req_wdata;
            r_n       <= w_n;
            r_cnt     <= '0;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we && w_st_align) begin
              r_state       <= WR;
              r_mem_we      <= 1'b1;
              r_mem_wr_addr <= req_addr[ADDR_W+1:2];
              r_mem_wr_strb <= w_al_strb;
              r_mem_wr_data <= w_al_data;
            end else if (req_we) begin
              r_state       <= WRB;
              r_mem_we      <= 1'b1;
              r_mem_wr_addr <= w_ba[ADDR_W+1:2];
              r_mem_wr_strb <= {1'b1, w_ba[1:0]};
              r_mem_wr_data <= {24'b0, w_byte};
            end else begin
              r_state       <= RD0;
              r_mem_rd_addr <= req_addr[ADDR_W+1:2];
            end
          end
        end
        WR: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
        end
        WRB: begin
          if ({1'b0, r_cnt} == (r_n - 3'd1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt         <= r_cnt + 2'd1;
            r_mem_we      <= 1'b1;
            r_mem_wr_addr <= w_ba[ADDR_W+1:2];
            r_mem_wr_strb <= {1'b1, w_ba[1:0]};
            r_mem_wr_data <= {24'b0, w_byte};
          end
        end
        RD0: begin
          if (w_r_cross) begin
            r_state       <= RD1;
            r_lo          <= mem_rd_data;
            r_mem_rd_addr <= r_addr_lo[ADDR_W+1:2] + ADDR_W'(1);
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_ext;
          end
        end
        RD1: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_ext;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign mem_we      = r_mem_we;
  assign mem_wr_strb = r_mem_wr_strb;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning data-memory depth in 32-bit words; ADDR_W = clog2(DEPTH).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, low-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  qualifies resp_valid; illegal funct3 or out-of-range address.
REQ-013 SHALL have port mem_rd_addr  output  ADDR_W  word index to data memory async read port.
REQ-014 SHALL have port mem_rd_data  input  32  async read data from data memory.
REQ-015 SHALL have ports mem_wr_addr  output  ADDR_W, mem_wr_data  output  32, mem_we  output  1, mem_wr_strb  output  3: data-memory write port; strb 000 word, 001 low half, 011 high half, 1kk byte kk.

Function
REQ-016 SHALL implement states IDLE, WR, WRB, RD0, RD1, RESP; req_ready SHALL be 1 exactly in IDLE.
REQ-017 SHALL accept on req_valid && req_ready, registering we, funct3, addr, wdata; all later behaviour SHALL use registered values only.
REQ-018 SHALL compute byte count n = 1/2/4 from funct3[1:0]; error if funct3 is not a legal code for req_we, or if any byte addr..addr+n-1 has bits [31:ADDR_W+2] nonzero (no wrap-around).
REQ-019 Error request: IDLE->RESP; no mem_we; resp_err=1, resp_rdata=0.
REQ-020 Aligned store (SW offset 0, SH offset 0/2, any SB): IDLE->WR->RESP; in WR mem_we=1 one cycle, strb 000 / 001 or 011 / 100+offset, wr_addr=addr[ADDR_W+1:2], data low-aligned, unused bits 0.
REQ-021 Misaligned store (SH offset 1/3, SW offset 1/2/3): IDLE->WRB for n cycles, byte i (i=0..n-1) written in cycle i at byte address addr+i, strb 100+((addr+i)&3), wr_addr (addr+i)>>2, mem_wr_data[7:0]=wdata byte i; then RESP.
REQ-022 Aligned load: IDLE->RD0->RESP; RD0 drives mem_rd_addr=word index, registers extracted result.
REQ-023 Misaligned load (LH/LHU offset 3, LW offset 1/2/3): IDLE->RD0->RD1->RESP; RD0 samples word w, RD1 samples word w+1; bytes assembled little-endian.
REQ-024 Extraction: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unmodified.
REQ-025 RESP SHALL last exactly one cycle with resp_valid=1, then IDLE; stores complete with resp_err=0, resp_rdata=0.
REQ-026 Latency from accept edge N: error/aligned response at N+1 (error) or N+2 (aligned); misaligned store N+1+n; misaligned load N+3.
REQ-027 mem_we SHALL be 0 outside WR/WRB; mem_rd_addr SHALL be 0 outside RD0/RD1; req_valid outside IDLE SHALL be ignored.

Reset
REQ-028 While rst=1: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wr_strb=000, all addresses/data 0.
REQ-029 rst mid-operation SHALL abort immediately: no further mem_we, no resp_valid; bytes already written remain.
REQ-030 First request SHALL be accepted on first rising edge after rst deasserts with req_valid=1.

Verification
REQ-031 SW addr 0x08 data 0xDEADBEEF -> one cycle mem_we, wr_addr 2, strb 000; resp_valid at N+2, err 0.
REQ-032 Mem word1=0x00008000; LH addr 0x04 -> resp_rdata 0xFFFF8000; LHU addr 0x04 -> 0x00008000.
REQ-033 SW addr 0x05 data 0x44332211 -> 4 byte writes: (w1,strb101,0x11),(w1,110,0x22),(w1,111,0x33),(w2,100,0x44); resp at N+5.
REQ-034 Words1,2 = 0xAABBCCDD,0x11223344; LW addr 0x07 -> RD0 w1, RD1 w2, resp_rdata 0x223344AA at N+3.
REQ-035 DEPTH=128: SW addr 0x1FE, or funct3 011 load -> resp_err=1 at N+1, mem_we never asserted.
REQ-036 rst asserted during 2nd cycle of misaligned SW -> mem_we drops at once, no resp_valid, req_ready=1.
